// File: rtl/conv_pool_sequencer.sv
// rtl/conv_pool_sequencer.sv - time-shares one 3x3 conv PE over all channels/pixels with fused ReLU and 2x2 max-pool
module conv_pool_sequencer #(
    parameter int INPUT_SIZE   = 32,
    parameter int KERNEL_SIZE  = 3,
    parameter int OUT_CHANNELS = 3,
    parameter int PX_SIZE      = 8,
    localparam int RAW_SIZE    = INPUT_SIZE - KERNEL_SIZE + 1,
    localparam int POOL_SIZE   = RAW_SIZE / 2,
    localparam int CW          = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1,
    localparam int RW          = $clog2(RAW_SIZE),
    localparam int PW          = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pe_req,
    output logic [CW-1:0]      pe_ch,
    output logic [RW-1:0]      pe_row,
    output logic [RW-1:0]      pe_col,
    input  logic               pe_ack,
    input  logic [PX_SIZE-1:0] pe_result,
    output logic               wr_en,
    output logic [CW-1:0]      wr_ch,
    output logic [PW-1:0]      wr_row,
    output logic [PW-1:0]      wr_col,
    output logic [PX_SIZE-1:0] wr_data
);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      ch;
    logic [PW-1:0]      pr;
    logic [PW-1:0]      pc;
    logic [1:0]         sub;
    logic [PX_SIZE-1:0] max_acc;
    logic [PX_SIZE-1:0] relu;
    logic               last_ch;
    logic               last_pr;
    logic               last_pc;

    // Negative PE results clamp to zero, so zero is the identity for the running max.
    assign relu    = pe_result[PX_SIZE-1] ? '0 : pe_result;
    assign last_ch = (ch == CW'(OUT_CHANNELS - 1));
    assign last_pr = (pr == PW'(POOL_SIZE - 1));
    assign last_pc = (pc == PW'(POOL_SIZE - 1));

    // State register; reset aborts any pass in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: four acked windows per pooled pixel, then one write cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = REQ;
            REQ:     if (pe_ack && (sub == 2'd3)) state_nx = WRITE;
            WRITE:   state_nx = (last_ch && last_pr && last_pc) ? DONE : REQ;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Loop counters and the per-window running max of ReLU'd results.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch      <= '0;
            pr      <= '0;
            pc      <= '0;
            sub     <= '0;
            max_acc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ch      <= '0;
                        pr      <= '0;
                        pc      <= '0;
                        sub     <= '0;
                        max_acc <= '0;
                    end
                end
                REQ: begin
                    if (pe_ack) begin
                        if (relu > max_acc) max_acc <= relu;
                        if (sub != 2'd3) sub <= sub + 2'd1;
                    end
                end
                WRITE: begin
                    max_acc <= '0;
                    sub     <= '0;
                    if (last_pc) begin
                        pc <= '0;
                        if (last_pr) begin
                            pr <= '0;
                            ch <= last_ch ? '0 : ch + 1'b1;
                        end else begin
                            pr <= pr + 1'b1;
                        end
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; sub selects the quadrant (dy = sub[1], dx = sub[0]).
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        pe_req  = 1'b0;
        pe_ch   = '0;
        pe_row  = '0;
        pe_col  = '0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        case (state)
            REQ: begin
                busy   = 1'b1;
                pe_req = 1'b1;
                pe_ch  = ch;
                pe_row = RW'({pr, 1'b0}) + RW'(sub[1]);
                pe_col = RW'({pc, 1'b0}) + RW'(sub[0]);
            end
            WRITE: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_ch   = ch;
                wr_row  = pr;
                wr_col  = pc;
                wr_data = max_acc;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_conv_pool_sequencer.sv
// tb/tb_conv_pool_sequencer.sv - scoreboard bench for conv_pool_sequencer
module tb_conv_pool_sequencer;

    localparam int POOL  = 15;
    localparam int NCH   = 3;
    localparam int NWR   = NCH * POOL * POOL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pe_req, pe_ack, wr_en;
    logic [1:0] pe_ch, wr_ch;
    logic [4:0] pe_row, pe_col;
    logic [3:0] wr_row, wr_col;
    logic [7:0] pe_result, wr_data;

    logic       start_s = 1'b0;
    logic       busy_s, done_s, pe_req_s, pe_ack_s, wr_en_s;
    logic [1:0] pe_ch_s, wr_ch_s;
    logic [2:0] pe_row_s, pe_col_s;
    logic [1:0] wr_row_s, wr_col_s;
    logic [7:0] pe_result_s, wr_data_s;

    conv_pool_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pe_req(pe_req), .pe_ch(pe_ch), .pe_row(pe_row), .pe_col(pe_col),
        .pe_ack(pe_ack), .pe_result(pe_result),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data)
    );

    conv_pool_sequencer #(.INPUT_SIZE(9)) u_small (
        .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
        .pe_req(pe_req_s), .pe_ch(pe_ch_s), .pe_row(pe_row_s), .pe_col(pe_col_s),
        .pe_ack(pe_ack_s), .pe_result(pe_result_s),
        .wr_en(wr_en_s), .wr_ch(wr_ch_s), .wr_row(wr_row_s), .wr_col(wr_col_s), .wr_data(wr_data_s)
    );

    assign pe_ack_s    = pe_req_s;
    assign pe_result_s = 8'(int'(pe_row_s) * 3 + int'(pe_col_s));

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int row;
        int col;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  mode   = 0;
    int  maxlat = 0;
    int  seed   = 0;
    int  wcnt   = 0;
    bit  drv_en = 1'b1;
    int  wr_count = 0;
    int  cap[NWR];
    int  last_ch, last_row, last_col;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Behavioural PE: a fixed function of the window coordinates for each mode.
    function automatic logic [7:0] pe_fn(input int m, input int c, input int r, input int k);
        case (m)
            0:       return 8'd5;
            1:       return 8'hFF;
            2:       return 8'((2 * r + k) & 127);
            default: return 8'(((c * 37) + (r * 11) + (k * 7) + seed) ^ (r * k));
        endcase
    endfunction

    function automatic int relu(input logic [7:0] v);
        return v[7] ? 0 : int'(v);
    endfunction

    // Reference: every pooled pixel in loop order is the max of ReLU over its 2x2 raw windows.
    task automatic build_expected();
        wr_t e;
        exp_q.delete();
        for (int c = 0; c < NCH; c++)
            for (int pr = 0; pr < POOL; pr++)
                for (int pc = 0; pc < POOL; pc++) begin
                    e.ch = c; e.row = pr; e.col = pc; e.data = 0;
                    for (int s = 0; s < 4; s++) begin
                        int v;
                        v = relu(pe_fn(mode, c, 2 * pr + s / 2, 2 * pc + s % 2));
                        if (v > e.data) e.data = v;
                    end
                    exp_q.push_back(e);
                end
    endtask

    // PE driver: acks each request after a random 0..maxlat cycle delay.
    initial begin
        pe_ack = 1'b0;
        pe_result = '0;
        forever begin
            @(negedge clk);
            if (drv_en && pe_req) begin
                if (wcnt == 0) begin
                    pe_ack    = 1'b1;
                    pe_result = pe_fn(mode, int'(pe_ch), int'(pe_row), int'(pe_col));
                    wcnt      = $urandom_range(0, maxlat);
                end else begin
                    pe_ack = 1'b0;
                    wcnt--;
                end
            end else if (drv_en) begin
                pe_ack = 1'b0;
            end
        end
    end

    // Monitor: scoreboard on writes, window bounds and request stability.
    logic       prev_req = 1'b0;
    logic [1:0] prev_ch;
    logic [4:0] prev_row, prev_col;
    always begin
        wr_t e;
        @(posedge clk);
        #1;
        if (!rst) begin
            if (wr_en) begin
                wr_count++;
                last_ch = int'(wr_ch); last_row = int'(wr_row); last_col = int'(wr_col);
                if (int'(wr_ch) < NCH && int'(wr_row) < POOL && int'(wr_col) < POOL)
                    cap[int'(wr_ch) * POOL * POOL + int'(wr_row) * POOL + int'(wr_col)] = int'(wr_data);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write ch=%0d row=%0d col=%0d data=%0d", wr_ch, wr_row, wr_col, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (int'(wr_ch) != e.ch || int'(wr_row) != e.row || int'(wr_col) != e.col || int'(wr_data) != e.data) begin
                        errors++;
                        $display("FAIL write actual=(%0d,%0d,%0d)=%0d expected=(%0d,%0d,%0d)=%0d",
                                 wr_ch, wr_row, wr_col, wr_data, e.ch, e.row, e.col, e.data);
                    end
                end
            end
            if (pe_req) begin
                checks++;
                if (pe_row > 5'd29 || pe_col > 5'd29) begin
                    errors++;
                    $display("FAIL req_bounds actual row=%0d col=%0d required<=29", pe_row, pe_col);
                end
                if (prev_req && !pe_ack) begin
                    checks++;
                    if (pe_ch != prev_ch || pe_row != prev_row || pe_col != prev_col) begin
                        errors++;
                        $display("FAIL req_stable actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                                 pe_ch, pe_row, pe_col, prev_ch, prev_row, prev_col);
                    end
                end
            end
        end
        prev_req = pe_req && !rst;
        prev_ch  = pe_ch;
        prev_row = pe_row;
        prev_col = pe_col;
    end

    task automatic run_pass(input int m, input int lat, input bit poke, output int n);
        mode = m;
        maxlat = lat;
        wcnt = 0;
        wr_count = 0;
        build_expected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        chk("start_busy", int'(busy), 1);
        chk("start_req", int'(pe_req), 1);
        chk("first_req_addr", int'({pe_ch, pe_row, pe_col}), 0);
        while (!done && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 500) start = 1'b1;
            if (poke && n == 501) start = 1'b0;
        end
        chk("done_seen", int'(done), 1);
        chk("done_busy_low", int'(busy), 0);
        chk("write_count", wr_count, NWR);
        chk("queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int n;
        int ws;
        int maxrc;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_req", int'(pe_req), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_addr", int'({pe_ch, pe_row, pe_col, wr_ch, wr_row, wr_col, wr_data}), 0);
        @(negedge clk);
        rst = 1'b0;

        run_pass(0, 0, 1'b0, n);
        chk("zero_wait_done_cycle", n, 3376);
        chk("final_write_addr", last_ch * 256 + last_row * 16 + last_col, 2 * 256 + 14 * 16 + 14);

        run_pass(1, 0, 1'b1, n);
        chk("neg_done_cycle", n, 3376);

        run_pass(2, 0, 1'b0, n);
        chk("pix_0_0_0", cap[0], 3);
        chk("pix_0_1_2", cap[1 * POOL + 2], 11);
        chk("pix_1_14_14", cap[POOL * POOL + 14 * POOL + 14], 87);

        seed = $urandom_range(0, 255);
        run_pass(3, 7, 1'b0, n);
        run_pass(0, 7, 1'b0, n);

        mode = 3;
        maxlat = 7;
        wcnt = 0;
        wr_count = 0;
        build_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (wr_count < 100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_100_writes", int'(wr_count >= 100), 1);
        n = 0;
        while (!pe_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        drv_en = 1'b0;
        pe_ack = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_outputs", int'({busy, done, pe_req, wr_en, pe_ch, pe_row, pe_col, wr_ch, wr_row, wr_col, wr_data}), 0);
        @(negedge clk);
        rst = 1'b0;
        pe_ack = 1'b1;
        pe_result = 8'h40;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("stale_ack_no_write", int'(wr_en), 0);
            chk("stale_ack_idle", int'(busy), 0);
        end
        @(negedge clk);
        pe_ack = 1'b0;
        drv_en = 1'b1;
        run_pass(3, 0, 1'b0, n);
        chk("restart_done_cycle", n, 3376);

        ws = 0;
        maxrc = 0;
        seen = 1'b0;
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (pe_req_s) begin
                if (int'(pe_row_s) > maxrc) maxrc = int'(pe_row_s);
                if (int'(pe_col_s) > maxrc) maxrc = int'(pe_col_s);
            end
            if (wr_en_s) begin
                ws++;
                chk("small_data", int'(wr_data_s), 3 * (2 * int'(wr_row_s) + 1) + 2 * int'(wr_col_s) + 1);
            end
            if (done_s) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("small_done", int'(seen), 1);
        chk("small_writes", ws, 27);
        chk("small_max_rowcol", maxrc, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_pool_sequencer.md
# conv_pool_sequencer

Sequential controller that time-shares a single 3x3 convolution processing element (PE) across every output channel and output pixel of a conv layer. It fuses ReLU and 2x2 max-pool on the fly and writes only pooled pixels to the feature-map buffer. This replaces the fully unrolled per-channel conv/relu/pool generate chain of the first network stage with one PE plus this scheduler.

## Interface
- INPUT_SIZE, 32, square input edge length in pixels
- KERNEL_SIZE, 3, square conv kernel edge
- OUT_CHANNELS, 3, number of conv output channels to sequence
- PX_SIZE, 8, bits per pixel; PE results are signed two's complement
- Derived values: RAW_SIZE = INPUT_SIZE-KERNEL_SIZE+1; POOL_SIZE = RAW_SIZE/2 (floor); CW = max(1,$clog2(OUT_CHANNELS)); RW = $clog2(RAW_SIZE); PW = $clog2(POOL_SIZE)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a full layer pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse at pass completion
- pe_req  out  1  request a conv window at (pe_ch, pe_row, pe_col)
- pe_ch  out  CW  output channel (kernel select)
- pe_row, pe_col  out  RW each  top-left corner of the raw conv window
- pe_ack  in  1  PE result valid; completes the current request
- pe_result  in  PX_SIZE  signed conv+bias result
- wr_en  out  1  pooled pixel write strobe
- wr_ch  out  CW; wr_row, wr_col  out  PW each  pooled pixel address
- wr_data  out  PX_SIZE  pooled, ReLU'd pixel (unsigned, MSB always 0)

## Operation
- FSM states: IDLE, REQ, WRITE, DONE.
- IDLE: all outputs 0. start=1 moves to REQ with ch=pr=pc=sub=0 and max_acc=0.
- Loop order, outer to inner: ch 0..OUT_CHANNELS-1, pr 0..POOL_SIZE-1, pc 0..POOL_SIZE-1, sub 0..3.
- sub maps to (dy,dx) = (0,0),(0,1),(1,0),(1,1).
- REQ: pe_req=1, pe_ch=ch, pe_row=2*pr+dy, pe_col=2*pc+dx. These values are held stable until pe_ack is sampled high.
- On pe_ack in REQ: relu = (pe_result[MSB] ? 0 : pe_result); max_acc <= max(max_acc, relu).
  - sub<3: sub++ and stay in REQ. pe_req stays high with the new coordinates the next cycle.
  - sub==3: go to WRITE.
- WRITE: wr_en=1 for one cycle with wr_ch=ch, wr_row=pr, wr_col=pc, wr_data=final max. pe_req=0.
  - Then clear max_acc and sub, and advance pc, then pr, then ch.
  - If the last pooled pixel of the last channel was written, go to DONE. Otherwise go to REQ.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- max_acc resets to 0 per pool window. ReLU output is ≥0, so 0 is the correct identity.
- Odd RAW_SIZE: the last raw row and column are never requested (floor pooling).
- pe_ack outside REQ is ignored. start outside IDLE is ignored.

## Timing
- Reset values: busy=0, done=0, pe_req=0, wr_en=0; all address/data outputs 0. FSM in IDLE.
- rst has priority over all other inputs in every state. A reset mid-pass aborts with no further write, and any stale pe_ack after reset is ignored.
- Start latency: start sampled high in IDLE at cycle t gives pe_req=1 and busy=1 at t+1.
- PE handshake: an ack may arrive in the first cycle of a request (zero-wait). With zero-wait acks, each pooled pixel takes exactly 5 cycles (4 REQ + 1 WRITE).
- Total pass with zero-wait acks: OUT_CHANNELS*POOL_SIZE^2*5 cycles of busy. done pulses the cycle after the final wr_en.
- The next start is accepted the cycle after done. There is no back-to-back start in the done cycle.

## Test plan
- Reset, start, PE acks same cycle with pe_result=5 (defaults): 675 writes all wr_data=5. Addresses are in ch/pr/pc order. The final write is at (2,14,14). done occurs 3376 cycles after start and lasts exactly one cycle.
- pe_result=-1 (0xFF) for every window: all 675 writes carry wr_data=0. No request has pe_row or pe_col above 29.
- pe_result=(2*pe_row+pe_col)&0x7F: write (0,0,0) gives 3; write (0,1,2) gives 11; write (1,14,14) gives 87.
- Random ack latency of 0–7 cycles: pe_ch/row/col are stable while pe_req=1 and unacked. Write count and data are identical to the zero-wait run.
- Assert rst after the 100th wr_en with an ack pending: the next cycle all outputs are 0. A pe_ack driven after reset produces no write. A new start restarts at request (0,0,0).
- start pulsed while busy causes no restart. INPUT_SIZE=9 (RAW 7, POOL 3): 27 writes, and row/col 6 is never requested.
